mac_array_unit: RTL and testbench

//   Parametrised multi-lane multiply-accumulate processing element for the DNN datapath.

---
 rtl/mac_array_unit.sv | 172 +++++++++++++++++
 tb/tb_mac_array_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mac_array_unit.sv
// mac_array_unit: multi-lane signed multiply-accumulate PE driving a single dest register.
// Define MAC_ARRAY_SAT_EN for a saturating accumulate and sum output with an ovf flag; otherwise results wrap.

module mac_array_lane #(
  parameter int D_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [D_WIDTH-1:0]   a,
  input  logic [D_WIDTH-1:0]   b,
  output logic [2*D_WIDTH-1:0] prod
);
  always_ff @(posedge clk) begin
    if (rst)     prod <= '0;
    else if (en) prod <= (2*D_WIDTH)'($signed(a)) * (2*D_WIDTH)'($signed(b));
  end
endmodule

module mac_array_unit #(
  parameter int D_WIDTH   = 16,
  parameter int I_WIDTH   = 4,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       clear_acc,
  input  logic [I_WIDTH-1:0]         index_in,
  input  logic [LANES*D_WIDTH-1:0]   a,
  input  logic [LANES*D_WIDTH-1:0]   b,
  input  logic [ACC_WIDTH-1:0]       dest_data_in,
  output logic                       ready,
  output logic                       pop,
  output logic                       dest_rd_en,
  output logic                       dest_wr_en,
  output logic [I_WIDTH-1:0]         dest_index,
  output logic [ACC_WIDTH-1:0]       dest_data_out,
  output logic                       done,
  output logic [D_WIDTH-1:0]         sum,
  output logic                       ovf
);
  localparam int SUM_HI = FRAC_BITS + D_WIDTH - 1;
`ifdef MAC_ARRAY_SAT_EN
  // Headroom so the lane sum plus partial sum can never wrap before clamping.
  localparam int EXT_W = ACC_WIDTH + $clog2(LANES) + 1;
`else
  localparam int EXT_W = ACC_WIDTH;
`endif

  typedef enum logic [2:0] {IDLE, FETCH, GET, MUL, ACC, STORE} state_t;
  state_t state, nxt;

  logic                                 accept;
  logic                                 clear_r;
  logic [LANES-1:0][D_WIDTH-1:0]        a_r, b_r;
  logic signed [ACC_WIDTH-1:0]          psum_r;
  logic [LANES-1:0][2*D_WIDTH-1:0]      prod;
  logic signed [EXT_W-1:0]              total;
  logic [ACC_WIDTH-1:0]                 acc_nxt;
  logic [D_WIDTH-1:0]                   sum_nxt;
`ifdef MAC_ARRAY_SAT_EN
  logic                                 acc_sat, sum_sat;
`endif

  // ready is a registered copy of "state is IDLE or STORE", low for one cycle after reset.
  assign accept = start & ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = FETCH;
      FETCH:   nxt = GET;
      GET:     nxt = MUL;
      MUL:     nxt = ACC;
      ACC:     nxt = STORE;
      STORE:   nxt = accept ? FETCH : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready      <= 1'b0;
      pop        <= 1'b0;
      dest_rd_en <= 1'b0;
      dest_wr_en <= 1'b0;
      done       <= 1'b0;
      dest_index <= '0;
      clear_r    <= 1'b0;
    end else begin
      ready      <= (nxt == IDLE) || (nxt == STORE);
      pop        <= (nxt == FETCH);
      dest_rd_en <= (nxt == FETCH);
      dest_wr_en <= (nxt == STORE);
      done       <= (nxt == STORE);
      if (accept) begin
        dest_index <= index_in;
        clear_r    <= clear_acc;
      end
    end
  end

  // Operand FIFOs and dest register present data one cycle after pop/rd_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      psum_r <= '0;
    end else if (state == GET) begin
      a_r    <= a;
      b_r    <= b;
      psum_r <= clear_r ? '0 : dest_data_in;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_array_lane #(.D_WIDTH(D_WIDTH)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (state == MUL),
      .a    (a_r[i]),
      .b    (b_r[i]),
      .prod (prod[i])
    );
  end

  always_comb begin
    total = EXT_W'(psum_r);
    for (int i = 0; i < LANES; i++) total = total + EXT_W'($signed(prod[i]));
`ifdef MAC_ARRAY_SAT_EN
    acc_sat = !((&total[EXT_W-1:ACC_WIDTH-1]) || !(|total[EXT_W-1:ACC_WIDTH-1]));
    acc_nxt = total[ACC_WIDTH-1:0];
    if (acc_sat) acc_nxt = total[EXT_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    sum_sat = !((&acc_nxt[ACC_WIDTH-1:SUM_HI]) || !(|acc_nxt[ACC_WIDTH-1:SUM_HI]));
    sum_nxt = acc_nxt[SUM_HI:FRAC_BITS];
    if (sum_sat) sum_nxt = acc_nxt[ACC_WIDTH-1] ? {1'b1, {(D_WIDTH-1){1'b0}}}
                                                : {1'b0, {(D_WIDTH-1){1'b1}}};
`else
    acc_nxt = total;
    sum_nxt = acc_nxt[SUM_HI:FRAC_BITS];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dest_data_out <= '0;
      sum           <= '0;
    end else if (state == ACC) begin
      dest_data_out <= acc_nxt;
      sum           <= sum_nxt;
    end
  end

`ifdef MAC_ARRAY_SAT_EN
  always_ff @(posedge clk) begin
    if (rst)                ovf <= 1'b0;
    else if (state == ACC)  ovf <= acc_sat | sum_sat;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac_array_unit.sv
// Directed scoreboard bench for mac_array_unit: expected results queued at accept, checked at done.
// Models the operand FIFOs and dest register with one-cycle read latency.
module tb_mac_array_unit;
  localparam int DW = 16, IW = 4, LN = 4, AW = 32, FB = 16;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, clear_acc = 1'b0;
  logic [IW-1:0]    index_in = '0;
  logic [LN*DW-1:0] a = '0, b = '0;
  logic [AW-1:0]    dest_data_in = '0;
  logic ready, pop, dest_rd_en, dest_wr_en, done, ovf;
  logic [IW-1:0] dest_index;
  logic [AW-1:0] dest_data_out;
  logic [DW-1:0] sum;

  mac_array_unit #(.D_WIDTH(DW), .I_WIDTH(IW), .LANES(LN), .ACC_WIDTH(AW), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst(rst), .start(start), .clear_acc(clear_acc), .index_in(index_in),
    .a(a), .b(b), .dest_data_in(dest_data_in), .ready(ready), .pop(pop),
    .dest_rd_en(dest_rd_en), .dest_wr_en(dest_wr_en), .dest_index(dest_index),
    .dest_data_out(dest_data_out), .done(done), .sum(sum), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [IW-1:0] idx;
    logic [AW-1:0] data;
    logic [DW-1:0] sm;
    logic          ov;
  } exp_t;

  exp_t                 expq[$];
  exp_t                 e;
  logic [2*LN*DW-1:0]   opq[$];
  logic [AW-1:0]        pre_mem [16];
  int cyc = 0, vectors = 0, errors = 0, pops = 0, exp_pops = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Source models: FIFO head and dest row appear the cycle after pop / rd_en.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dest_rd_en) dest_data_in <= pre_mem[dest_index];
    if (pop && opq.size() > 0) {a, b} <= opq.pop_front();
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (pop) pops++;
      if (dest_wr_en || done) begin
        chk("done_eq_wr", done, dest_wr_en);
        if (expq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = expq.pop_front();
          chk("latency",   cyc,           e.cyc);
          chk("index",     dest_index,    e.idx);
          chk("data",      dest_data_out, e.data);
          chk("sum",       sum,           e.sm);
          chk("ovf",       ovf,           e.ov);
        end
      end
    end
  end

  function automatic void model(input logic [LN*DW-1:0] av, input logic [LN*DW-1:0] bv,
                                input logic [AW-1:0] din, input logic clr,
                                output logic [AW-1:0] d, output logic [DW-1:0] s, output logic o);
    longint t, hi;
    t = clr ? 64'sd0 : longint'($signed(din));
    for (int i = 0; i < LN; i++)
      t += longint'($signed(av[i*DW +: DW])) * longint'($signed(bv[i*DW +: DW]));
    o = 1'b0;
`ifdef MAC_ARRAY_SAT_EN
    if (t > 64'sd2147483647)       begin t = 64'sd2147483647;  o = 1'b1; end
    else if (t < -64'sd2147483648) begin t = -64'sd2147483648; o = 1'b1; end
    d  = t[AW-1:0];
    hi = t >>> FB;
    if (hi > 64'sd32767)        begin s = 16'h7FFF; o = 1'b1; end
    else if (hi < -64'sd32768)  begin s = 16'h8000; o = 1'b1; end
    else s = hi[DW-1:0];
`else
    d = t[AW-1:0];
    s = d[FB+DW-1:FB];
    hi = 0;
`endif
  endfunction

  task automatic op(input logic clr, input logic [IW-1:0] idx,
                    input logic [LN*DW-1:0] av, input logic [LN*DW-1:0] bv, input logic [AW-1:0] din,
                    input logic [AW-1:0] ed, input logic [DW-1:0] es, input logic eo,
                    input bit keep, input bit exp_done);
    int t = 0;
    exp_t x;
    while (ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) chk("ready_timeout", 0, 1);
    start = 1'b1; clear_acc = clr; index_in = idx;
    pre_mem[idx] = din;
    opq.push_back({av, bv});
    exp_pops++;
    x.cyc = cyc + 5; x.idx = idx; x.data = ed; x.sm = es; x.ov = eo;
    if (exp_done) expq.push_back(x);
    @(negedge clk);
    if (!keep) start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (expq.size() > 0 && t < 30) begin @(negedge clk); t++; end
    chk("drain", expq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {ready, pop, dest_rd_en, dest_wr_en, done, dest_index, sum, ovf}, 0);
    chk({tag, "_data"}, dest_data_out, 0);
  endtask

  logic [LN*DW-1:0] ra, rb;
  logic [AW-1:0]    rd, ed;
  logic [DW-1:0]    es;
  logic             eo, rc;

  initial begin
    for (int i = 0; i < 16; i++) pre_mem[i] = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", ready, 1);

    op(1, 4'd3, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 32'hDEAD_BEEF,
       32'd70, 16'h0000, 1'b0, 0, 1);
    drain();
    op(0, 4'd5, {4{16'h0100}}, {4{16'h0100}}, 32'h0001_0000, 32'h0005_0000, 16'h0005, 1'b0, 0, 1);
    drain();
    op(1, 4'd7, {48'h0, 16'hFFFD}, {48'h0, 16'h0002}, 32'h1234_5678,
       32'hFFFF_FFFA, 16'hFFFF, 1'b0, 0, 1);
    drain();
`ifdef MAC_ARRAY_SAT_EN
    op(0, 4'd1, {48'h0, 16'h1}, {48'h0, 16'h1}, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 16'h7FFF, 1'b1, 0, 1);
`else
    op(0, 4'd1, {48'h0, 16'h1}, {48'h0, 16'h1}, 32'h7FFF_FFFF, 32'h8000_0000, 16'h8000, 1'b0, 0, 1);
`endif
    drain();

    // start held through STORE: back-to-back ops, one every 5 cycles
    for (int k = 0; k < 3; k++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rd = $urandom; rc = k[0];
      model(ra, rb, rd, rc, ed, es, eo);
      op(rc, IW'(k + 2), ra, rb, rd, ed, es, eo, 1, 1);
    end
    start = 1'b0;
    drain();

    // start pulsed during MUL must be ignored
    op(1, 4'd4, {16'd1, 16'd1, 16'd1, 16'd1}, {16'd2, 16'd2, 16'd2, 16'd2}, 32'h0,
       32'd8, 16'h0000, 1'b0, 0, 1);
    @(negedge clk); @(negedge clk);
    start = 1'b1; index_in = 4'd9;
    @(negedge clk);
    start = 1'b0;
    drain();

    // reset during ACC abandons the op
    op(1, 4'd6, {4{16'h0010}}, {4{16'h0010}}, 32'h0, 32'h0, 16'h0, 1'b0, 0, 0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_mid_op");
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("no_wr_after_abort", expq.size(), 0);

    for (int k = 0; k < 4; k++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rd = $urandom; rc = $urandom_range(0, 1);
      model(ra, rb, rd, rc, ed, es, eo);
      op(rc, IW'($urandom_range(0, 15)), ra, rb, rd, ed, es, eo, 0, 1);
      drain();
    end

    chk("pop_count", pops, exp_pops);
    chk("fifo_empty", opq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
